// File: rtl/multicycle_core_ctrl.sv
// Multi-cycle RV32 sequencer: IDLE -> FETCH -> EXEC -> [MEM] -> WB, with sticky ebreak halt and error states.
// Latency: ALU op 3 cycles + fetch wait; load/store 4 cycles + fetch wait + memory wait.
// Backpressure: requests are held until the matching rvalid; a bounded wait counter forces ERR on a stalled memory.
module multicycle_core_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(32'h80000000),
    parameter int                    TIMEOUT    = 255,
    parameter int                    CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] pc,
    output logic                  ifu_req,
    input  logic                  ifu_rvalid,
    input  logic [31:0]           ifu_rdata,
    output logic [31:0]           inst,
    input  logic                  dec_load,
    input  logic                  dec_store,
    input  logic                  dec_ebreak,
    input  logic                  exu_jump,
    input  logic [DATA_WIDTH-1:0] exu_upc,
    input  logic                  reg_wen_in,
    input  logic                  csr_wen_in,
    output logic                  reg_wen,
    output logic                  csr_wen,
    output logic                  lsu_req,
    output logic                  lsu_wen,
    input  logic                  lsu_rvalid,
    output logic [CNT_WIDTH-1:0]  retired,
    output logic                  exit,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_ERR
    } state_t;

    // The counter only has to reach TIMEOUT-1: the cycle that would make it TIMEOUT is the failing one.
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t                state;
    logic [WW-1:0]         wait_cnt;
    logic                  timeout_hit;
    logic [DATA_WIDTH-1:0] next_pc;

    // Last permitted waiting cycle; a response arriving in it still wins.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == WW'(TIMEOUT - 1));

    // Successor PC, evaluated while in WB; natural wrap at 2^DATA_WIDTH.
    assign next_pc = exu_jump ? exu_upc : pc + DATA_WIDTH'(4);

    // Write enables follow the combinational EXU requests, so they can only be gated, not registered.
    always_comb begin
        reg_wen = 1'b0;
        csr_wen = 1'b0;
        if (state == S_WB) begin
            reg_wen = reg_wen_in;
            csr_wen = csr_wen_in;
        end
    end

    // Sequencer: state, PC, instruction latch, counters and registered request/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            inst     <= 32'h0;
            retired  <= '0;
            wait_cnt <= '0;
            ifu_req  <= 1'b0;
            lsu_req  <= 1'b0;
            lsu_wen  <= 1'b0;
            exit     <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_FETCH;
                    ifu_req  <= 1'b1;
                    wait_cnt <= '0;
                end
                S_FETCH: begin
                    if (ifu_rvalid) begin
                        inst    <= ifu_rdata;
                        ifu_req <= 1'b0;
                        state   <= S_EXEC;
                    end else if (timeout_hit) begin
                        ifu_req <= 1'b0;
                        err     <= 1'b1;
                        state   <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                S_EXEC: begin
                    if (dec_ebreak) begin
                        exit  <= 1'b1;
                        state <= S_HALT;
                    end else if (dec_load || dec_store) begin
                        lsu_req  <= 1'b1;
                        lsu_wen  <= dec_store;
                        wait_cnt <= '0;
                        state    <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (lsu_rvalid) begin
                        lsu_req <= 1'b0;
                        lsu_wen <= 1'b0;
                        state   <= S_WB;
                    end else if (timeout_hit) begin
                        lsu_req <= 1'b0;
                        lsu_wen <= 1'b0;
                        err     <= 1'b1;
                        state   <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                S_WB: begin
                    // A misaligned successor is fatal; the offending instruction is not retired.
                    if (next_pc[1:0] != 2'b00) begin
                        err   <= 1'b1;
                        state <= S_ERR;
                    end else begin
                        pc       <= next_pc;
                        retired  <= retired + CNT_WIDTH'(1);
                        ifu_req  <= 1'b1;
                        wait_cnt <= '0;
                        state    <= S_FETCH;
                    end
                end
                S_HALT:  state <= S_HALT;
                S_ERR:   state <= S_ERR;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_core_ctrl.sv
module tb_multicycle_core_ctrl;

    localparam logic [31:0] RST_PC = 32'h80000000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        ifu_req;
    logic        ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic [31:0] inst;
    logic        dec_load, dec_store, dec_ebreak;
    logic        exu_jump;
    logic [31:0] exu_upc;
    logic        reg_wen_in, csr_wen_in;
    logic        reg_wen, csr_wen;
    logic        lsu_req, lsu_wen, lsu_rvalid;
    logic [31:0] retired;
    logic        exit, err;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: architectural PC and retired count, advanced per instruction.
    logic [31:0] m_pc;
    logic [31:0] m_ret;

    always #5 clk = ~clk;

    multicycle_core_ctrl #(
        .DATA_WIDTH(32),
        .RESET_PC  (RST_PC),
        .TIMEOUT   (4),
        .CNT_WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .ifu_req   (ifu_req),
        .ifu_rvalid(ifu_rvalid),
        .ifu_rdata (ifu_rdata),
        .inst      (inst),
        .dec_load  (dec_load),
        .dec_store (dec_store),
        .dec_ebreak(dec_ebreak),
        .exu_jump  (exu_jump),
        .exu_upc   (exu_upc),
        .reg_wen_in(reg_wen_in),
        .csr_wen_in(csr_wen_in),
        .reg_wen   (reg_wen),
        .csr_wen   (csr_wen),
        .lsu_req   (lsu_req),
        .lsu_wen   (lsu_wen),
        .lsu_rvalid(lsu_rvalid),
        .retired   (retired),
        .exit      (exit),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Synchronous reset, check the reset state, then let IDLE advance into FETCH.
    task automatic do_reset();
        rst        = 1'b1;
        ifu_rvalid = 1'($urandom_range(0, 1));
        lsu_rvalid = 1'($urandom_range(0, 1));
        tick();
        rst        = 1'b0;
        ifu_rvalid = 1'b0;
        lsu_rvalid = 1'b0;
        m_pc       = RST_PC;
        m_ret      = 0;
        chk("rst_pc", pc, RST_PC);
        chk("rst_inst", inst, 0);
        chk("rst_retired", retired, 0);
        chk("rst_ifu_req", ifu_req, 0);
        chk("rst_lsu_req", lsu_req, 0);
        chk("rst_lsu_wen", lsu_wen, 0);
        chk("rst_exit", exit, 0);
        chk("rst_err", err, 0);
        tick();
    endtask

    // One instruction from its first FETCH cycle. kind: 0 alu, 1 load, 2 store, 3 ebreak.
    task automatic run_instr(input int kind, input int fw, input int mw, input bit jmp,
                             input logic [31:0] tgt, input bit rw, input bit cw);
        logic [31:0] word;
        logic [31:0] nxt;
        word       = (kind == 3) ? 32'h00100073 : $urandom;
        dec_load   = (kind == 1);
        dec_store  = (kind == 2);
        dec_ebreak = (kind == 3);
        exu_jump   = jmp;
        exu_upc    = tgt;
        reg_wen_in = rw;
        csr_wen_in = cw;
        for (int c = 0; c <= fw; c++) begin
            chk("fetch_req", ifu_req, 1);
            chk("fetch_pc", pc, m_pc);
            chk("fetch_reg_wen", reg_wen, 0);
            chk("fetch_lsu_req", lsu_req, 0);
            ifu_rvalid = (c == fw);
            ifu_rdata  = (c == fw) ? word : $urandom;
            lsu_rvalid = 1'($urandom_range(0, 1));
            tick();
        end
        chk("exec_inst", inst, word);
        chk("exec_ifu_req", ifu_req, 0);
        chk("exec_reg_wen", reg_wen, 0);
        chk("exec_csr_wen", csr_wen, 0);
        ifu_rvalid = 1'($urandom_range(0, 1));
        lsu_rvalid = 1'($urandom_range(0, 1));
        tick();
        if (kind == 3) begin
            chk("halt_exit", exit, 1);
            chk("halt_ifu_req", ifu_req, 0);
            chk("halt_pc", pc, m_pc);
            chk("halt_retired", retired, m_ret);
            ifu_rvalid = 1'b0;
            lsu_rvalid = 1'b0;
            return;
        end
        if (kind == 1 || kind == 2) begin
            for (int c = 0; c <= mw; c++) begin
                chk("mem_req", lsu_req, 1);
                chk("mem_wen", lsu_wen, (kind == 2));
                chk("mem_reg_wen", reg_wen, 0);
                lsu_rvalid = (c == mw);
                ifu_rvalid = 1'($urandom_range(0, 1));
                tick();
            end
        end
        chk("wb_reg_wen", reg_wen, rw);
        chk("wb_csr_wen", csr_wen, cw);
        chk("wb_lsu_req", lsu_req, 0);
        chk("wb_ifu_req", ifu_req, 0);
        nxt        = jmp ? tgt : m_pc + 32'd4;
        ifu_rvalid = 1'($urandom_range(0, 1));
        lsu_rvalid = 1'($urandom_range(0, 1));
        tick();
        ifu_rvalid = 1'b0;
        lsu_rvalid = 1'b0;
        if (nxt[1:0] != 2'b00) begin
            chk("err_flag", err, 1);
            chk("err_pc", pc, m_pc);
            chk("err_retired", retired, m_ret);
            chk("err_ifu_req", ifu_req, 0);
        end else begin
            m_pc  = nxt;
            m_ret = m_ret + 1;
            chk("wb_pc", pc, m_pc);
            chk("wb_retired", retired, m_ret);
            chk("next_fetch_req", ifu_req, 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ifu_rvalid = 1'b0; ifu_rdata = '0; dec_load = 1'b0; dec_store = 1'b0;
        dec_ebreak = 1'b0; exu_jump = 1'b0; exu_upc = '0; reg_wen_in = 1'b0;
        csr_wen_in = 1'b0; lsu_rvalid = 1'b0;

        // Basic ALU op, store with 3-cycle memory delay, load with fetch on the last allowed cycle, jump.
        do_reset();
        run_instr(0, 0, 0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("addi_pc", pc, 32'h80000004);
        run_instr(2, 0, 3, 1'b0, 32'h0, 1'b0, 1'b0);
        run_instr(1, 3, 2, 1'b0, 32'h0, 1'b1, 1'b1);
        run_instr(0, 1, 0, 1'b1, 32'h80000100, 1'b1, 1'b0);
        chk("jump_pc", pc, 32'h80000100);

        // Randomized mix of ALU/load/store with aligned jumps and random waits.
        for (int i = 0; i < 40; i++) begin
            int   k;
            bit   j;
            logic [31:0] t;
            k = int'($urandom_range(0, 2));
            j = ($urandom_range(0, 3) == 0);
            t = $urandom & 32'hFFFFFFFC;
            run_instr(k, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), j, t,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Misaligned jump target: writes still happen in WB, then sticky ERR.
        run_instr(0, 0, 0, 1'b1, 32'h80000102, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            ifu_rvalid = 1'b1;
            tick();
            chk("err_sticky", err, 1);
            chk("err_exit", exit, 0);
            chk("err_quiet_req", ifu_req, 0);
            chk("err_quiet_wen", reg_wen, 0);
        end
        ifu_rvalid = 1'b0;

        // Fetch timeout: four waiting cycles without a response.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            chk("to_req", ifu_req, 1);
            chk("to_err_pre", err, 0);
            tick();
        end
        chk("to_err", err, 1);
        chk("to_req_drop", ifu_req, 0);
        tick();
        chk("to_req_stay", ifu_req, 0);

        // ebreak halt, immune to later fetch responses.
        do_reset();
        run_instr(3, int'($urandom_range(0, 3)), 0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            ifu_rvalid = 1'b1;
            ifu_rdata  = $urandom;
            tick();
            chk("halt_sticky", exit, 1);
            chk("halt_quiet", ifu_req, 0);
            chk("halt_noerr", err, 0);
            chk("halt_nocount", retired, 0);
        end
        ifu_rvalid = 1'b0;

        // Reset in the middle of a load's memory wait.
        do_reset();
        run_instr(0, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
        dec_load   = 1'b1; dec_store = 1'b0; dec_ebreak = 1'b0; exu_jump = 1'b0;
        ifu_rvalid = 1'b1;
        ifu_rdata  = $urandom;
        tick();
        ifu_rvalid = 1'b0;
        tick();
        chk("mid_mem_req", lsu_req, 1);
        rst        = 1'b1;
        lsu_rvalid = 1'b1;
        tick();
        chk("mid_rst_lsu_req", lsu_req, 0);
        chk("mid_rst_retired", retired, 0);
        chk("mid_rst_pc", pc, RST_PC);
        chk("mid_rst_ifu_req", ifu_req, 0);
        rst        = 1'b0;
        lsu_rvalid = 1'b0;
        tick();
        chk("mid_rst_fetch", ifu_req, 1);
        m_pc  = RST_PC;
        m_ret = 0;
        run_instr(0, 0, 0, 1'b0, 32'h0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_core_ctrl.md
Name: multicycle_core_ctrl

Overview:
- Multi-cycle sequencer for the RV32 core; generalised successor to the single-cycle top.
- Replaces "everything in one clock" with an FSM: FETCH, EXEC, MEM, WB.
- Adds a valid-handshaked instruction and data memory interface, PC ownership, write-enable gating, a retired-instruction counter, timeout/misalignment error detection and a sticky ebreak halt.
- Sits between IFU/LSU and the existing IDU/EXU/RegisterFile/CSRU, which remain combinational.

Parameters:
- DATA_WIDTH, 32, datapath and PC width
- RESET_PC, 32'h80000000, PC value loaded on reset
- TIMEOUT, 255, maximum cycles waiting for a memory response; 0 disables the timeout
- CNT_WIDTH, 32, width of the retired-instruction counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pc  out  DATA_WIDTH  current PC; also the IFU address
- ifu_req  out  1  instruction fetch request
- ifu_rvalid  in  1  fetch data valid
- ifu_rdata  in  32  fetched instruction
- inst  out  32  latched instruction, fed to IDU
- dec_load  in  1  decoded load
- dec_store  in  1  decoded store
- dec_ebreak  in  1  decoded ebreak (32'h00100073)
- exu_jump  in  1  branch/jump taken
- exu_upc  in  DATA_WIDTH  jump/trap target from EXU/CSRU mux
- reg_wen_in  in  1  EXU register write request
- csr_wen_in  in  1  EXU CSR write request
- reg_wen  out  1  gated register-file write enable
- csr_wen  out  1  gated CSR write enable
- lsu_req  out  1  data memory request
- lsu_wen  out  1  data memory write qualifier
- lsu_rvalid  in  1  data access complete
- retired  out  CNT_WIDTH  retired-instruction count
- exit  out  1  sticky ebreak halt
- err  out  1  sticky error (timeout or misaligned PC)

Behaviour:
- Reset (synchronous, in any state, aborting any access):
  - state=IDLE, pc=RESET_PC, inst=0, retired=0.
  - ifu_req, lsu_req, lsu_wen, reg_wen, csr_wen, exit, err all 0.
- States: IDLE, FETCH, EXEC, MEM, WB, HALT, ERR.
- IDLE:
  - Lasts one cycle, then FETCH.
- FETCH:
  - ifu_req=1 held every cycle until ifu_rvalid is sampled high.
  - On that edge: inst<=ifu_rdata, go to EXEC, ifu_req drops the following cycle.
  - Zero-wait response (rvalid in the first FETCH cycle) is legal.
- EXEC (exactly one cycle; IDU/EXU settle combinationally from inst):
  - dec_ebreak takes priority: go to HALT.
  - Else dec_load|dec_store: go to MEM.
  - Else go to WB.
- MEM:
  - lsu_req=1 and lsu_wen=dec_store, both held until lsu_rvalid; then WB.
- WB (exactly one cycle):
  - reg_wen=reg_wen_in and csr_wen=csr_wen_in for this cycle only; both are 0 in every other state.
  - Next PC = exu_jump ? exu_upc : pc+4, modulo 2^DATA_WIDTH.
  - If next PC[1:0]!=0: go to ERR, pc unchanged, retired unchanged; writes in this WB still occur.
  - Otherwise: pc<=next PC, retired<=retired+1 (wraps at 2^CNT_WIDTH), go to FETCH.
- Timeout:
  - Wait counter clears on entry to FETCH and MEM and increments every waiting cycle.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT without a response: go to ERR.
  - A response in the same cycle the counter reaches TIMEOUT wins; no error.
- HALT:
  - exit=1 from the cycle after EXEC; all requests and enables stay 0 until rst.
  - ebreak is not counted in retired.
- ERR:
  - err=1, exit=0; all requests and enables stay 0 until rst.
- Spurious inputs:
  - ifu_rvalid outside FETCH and lsu_rvalid outside MEM are ignored.
- Latency:
  - ALU instruction: 3 cycles + fetch wait.
  - Load/store: 4 cycles + fetch wait + memory wait.

Test Plan:
- Reset, then ifu_rvalid=1 every cycle with addi → after reset: IDLE 1 cycle, FETCH, EXEC, WB; reg_wen=1 only in WB; pc 80000000→80000004; retired=1.
- Store with lsu_rvalid delayed 3 cycles → lsu_req=1 and lsu_wen=1 for 4 cycles; reg_wen never asserted; total 7 cycles from FETCH to next FETCH.
- Jump with exu_jump=1, exu_upc=80000100 → pc=80000100 after WB. Repeat with exu_upc=80000102 → err=1, pc stays, retired unchanged.
- TIMEOUT=4, ifu_rvalid held 0 → ERR entered after 4 wait cycles; ifu_req=0 afterwards. Repeat with rvalid arriving on the 4th wait cycle → no error.
- inst 00100073 → exit=1 one cycle after EXEC, sticky; later ifu_rvalid pulses ignored; rst clears exit and pc=RESET_PC.
- rst asserted mid-MEM → next cycle lsu_req=0, state IDLE, retired=0; lsu_rvalid in that cycle is ignored.
